regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3: number of write-back requesters, range 2..8.
REQ-002 Parameter ADDR_W, default 5: register address width.
REQ-003 Parameter DATA_W, default 32: register data width.
REQ-004 The module SHALL provide these ports:
- Clk, input, 1: the single clock; all state updates on the rising edge.
- Reset, input, 1: asynchronous, active-high reset.
- req, input, NUM_REQ: per-requester write request; held high until granted.
- req_addr, input, NUM_REQ*ADDR_W: flattened destination addresses; requester i occupies slice i.
- req_data, input, NUM_REQ*DATA_W: flattened write data; requester i occupies slice i.
- gnt, output, NUM_REQ: one-hot grant, combinational, valid in the arbitration cycle.
- RegWrite, output, 1: registered write enable to the register file.
- WriteRegister, output, ADDR_W: registered write address.
- WriteData, output, DATA_W: registered write data.
- wr_count, output, 16: count of committed writes.
- ReadRegister1 and ReadRegister2, input, ADDR_W each: read addresses, used for bypass.
- fwd_hit1 and fwd_hit2, output, 1 each: bypass match flags.
- fwd_data1 and fwd_data2, output, DATA_W each: bypass data.

Function
REQ-005 gnt SHALL be zero, or one-hot among the set bits of req, every cycle.
REQ-006 Arbitration SHALL be round-robin: search starts at pointer ptr and proceeds upward modulo NUM_REQ; the first requester with req set wins.
REQ-007 On a grant to requester w, ptr SHALL load (w+1) mod NUM_REQ at the next edge; with no grant, ptr is unchanged.
REQ-008 A requester SHALL drop req in the cycle after its gnt, or re-request for a new write; each gnt consumes exactly one write.
REQ-009 Latency SHALL be one cycle: the winner's address and data appear on WriteRegister/WriteData, with RegWrite=1, in the cycle after gnt.
REQ-010 A granted request with address 0 SHALL be consumed (gnt asserted) but SHALL produce RegWrite=0 and SHALL not increment wr_count.
REQ-011 With no grant, RegWrite SHALL be 0 in the next cycle; WriteRegister/WriteData hold their previous values.
REQ-012 Throughput SHALL be one write per cycle under continuous requests; no idle cycle is inserted between back-to-back grants.
REQ-013 wr_count SHALL increment on every cycle with RegWrite=1 and saturate at 0xFFFF.
REQ-014 The arbiter SHALL run as a 2-state FSM, IDLE and ISSUE: ISSUE is entered in the cycle after any non-zero-address grant, otherwise IDLE. RegWrite=1 exactly in ISSUE.

Reset
REQ-015 While Reset=1 the following SHALL clear asynchronously: RegWrite=0, WriteRegister=0, WriteData=0, wr_count=0, ptr=0, FSM=IDLE.
REQ-016 While Reset=1, gnt SHALL be all-zero.
REQ-017 A write registered but not yet committed when Reset asserts SHALL be discarded.
REQ-018 Arbitration SHALL resume on the first rising edge after Reset deasserts, starting from requester 0.

Configuration
REQ-019 With macro REGWB_BYPASS_EN defined: fwd_hitN=1 when RegWrite=1, WriteRegister==ReadRegisterN and ReadRegisterN!=0, with fwd_dataN=WriteData; otherwise fwd_hitN=0 and fwd_dataN=0.
REQ-020 Without REGWB_BYPASS_EN, all bypass ports SHALL remain present: fwd_hit1/2 tied 0, fwd_data1/2 tied 0, ReadRegister1/2 ignored.

Structure
REQ-021 Package regwb_pkg SHALL hold the default ADDR_W, DATA_W and NUM_REQ constants, the ZERO_REG constant (0), the FSM state typedef (IDLE, ISSUE) and the WR_COUNT_MAX constant (0xFFFF).
REQ-022 The round-robin picker SHALL be a sub-module rr_arbiter: combinational, with inputs req and ptr and output one-hot gnt.

Verification
REQ-023 Single request: req=001, addr 5, data 0x1234 -> gnt=001 in cycle 0; cycle 1: RegWrite=1, WriteRegister=5, WriteData=0x1234; wr_count=1.
REQ-024 Fairness: req=111 held for 6 cycles starting with ptr=0 -> grant order 0,1,2,0,1,2; RegWrite=1 in cycles 1..6.
REQ-025 Zero register: requester 1 alone writes addr 0, data 0xFFFF_FFFF -> gnt=010; next cycle RegWrite=0; wr_count unchanged.
REQ-026 Mid-operation reset: Reset asserted between gnt and the commit edge -> RegWrite stays 0 and wr_count=0; after release, req=100 is granted as gnt=100 by the first edge.
REQ-027 Bypass, with REGWB_BYPASS_EN: commit to addr 7, data 0xCAFE, with ReadRegister1=7 and ReadRegister2=0 -> fwd_hit1=1, fwd_data1=0xCAFE, fwd_hit2=0. Without the macro: both hits 0.
REQ-028 Saturation: wr_count preloaded near 0xFFFF, then 3 more commits -> wr_count=0xFFFF and holds.

Source files
------------

// File: rtl/regwb_pkg.sv
// -----------------------------------------------------------------------------
// regwb_pkg
// Shared constants and types for the register-file write-back arbiter.
//   DEF_NUM_REQ / DEF_ADDR_W / DEF_DATA_W : default parameter values
//   ZERO_REG     : hard-wired zero register address (writes to it are dropped)
//   WR_COUNT_MAX : saturation value of the committed-write counter
//   regwb_state_e: write-back FSM state (IDLE, ISSUE)
// -----------------------------------------------------------------------------
package regwb_pkg;

    localparam int DEF_NUM_REQ = 3;
    localparam int DEF_ADDR_W  = 5;
    localparam int DEF_DATA_W  = 32;

    localparam int          ZERO_REG     = 0;
    localparam logic [15:0] WR_COUNT_MAX = 16'hFFFF;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } regwb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker. The search starts at index ptr and walks
// upward modulo N; the first set request bit wins.
// Ports:
//   req [N-1:0]     : request vector
//   ptr [PTR_W-1:0] : highest-priority index for this cycle (always < N)
//   gnt [N-1:0]     : one-hot grant, all-zero when no request is set
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N     = 3,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt
);

    always_comb begin
        int   idx;
        logic found;
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            // Rotate the search so it begins at ptr and wraps past N-1.
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
// Round-robin arbiter that merges NUM_REQ write-back requesters into a single
// registered register-file write port, with an optional read bypass.
//
// Handshake: a requester holds req[i] high until it sees gnt[i] in the same
// cycle; each grant consumes exactly one write, and the requester must drop
// req[i] (or present a new write) in the following cycle. The granted write
// appears on RegWrite/WriteRegister/WriteData one cycle after the grant.
//
// Ports:
//   Clk, Reset                    : clock, asynchronous active-high reset
//   req, req_addr, req_data       : per-requester request, flattened addr/data
//   gnt                           : one-hot combinational grant
//   RegWrite, WriteRegister,
//   WriteData                     : registered write port to the register file
//   wr_count                      : saturating count of committed writes
//   ReadRegister1/2               : read addresses compared for bypass
//   fwd_hit1/2, fwd_data1/2       : bypass hit flags and data
//   fsmState                      : current write-back FSM state (debug)
//
// Build option: define REGWB_BYPASS_EN to enable the read bypass; without it
// the bypass outputs are tied to zero and ReadRegister1/2 are ignored.
// -----------------------------------------------------------------------------
module regfile_wb_arbiter
    import regwb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      RegWrite,
    output logic [ADDR_W-1:0]         WriteRegister,
    output logic [DATA_W-1:0]         WriteData,
    output logic [15:0]               wr_count,
    input  logic [ADDR_W-1:0]         ReadRegister1,
    input  logic [ADDR_W-1:0]         ReadRegister2,
    output logic                      fwd_hit1,
    output logic                      fwd_hit2,
    output logic [DATA_W-1:0]         fwd_data1,
    output logic [DATA_W-1:0]         fwd_data2,
    output regwb_state_e              fsmState
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    regwb_state_e      state, stateNext;
    logic [PTR_W-1:0]  ptr, ptrNext;
    logic [NUM_REQ-1:0] rawGnt;
    logic              anyGnt;
    logic              commitValid;
    logic [PTR_W-1:0]  winIdx;
    logic [ADDR_W-1:0] selAddr;
    logic [DATA_W-1:0] selData;
    logic [15:0]       wrCount;

    rr_arbiter #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .req (req),
        .ptr (ptr),
        .gnt (rawGnt)
    );

    // Grants are suppressed for the whole reset window, not only at edges.
    assign gnt = Reset ? '0 : rawGnt;

    // Encode the one-hot grant and select the winner's address and data.
    always_comb begin
        anyGnt  = 1'b0;
        winIdx  = '0;
        selAddr = '0;
        selData = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                anyGnt  = 1'b1;
                winIdx  = PTR_W'(i);
                selAddr = req_addr[i*ADDR_W +: ADDR_W];
                selData = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // A grant to the zero register is consumed but never becomes a write.
    assign commitValid = anyGnt && (selAddr != ADDR_W'(ZERO_REG));

    // Next-state and pointer logic.
    always_comb begin
        stateNext = IDLE;
        ptrNext   = ptr;
        if (commitValid) begin
            stateNext = ISSUE;
        end
        if (anyGnt) begin
            ptrNext = (winIdx == PTR_W'(NUM_REQ - 1)) ? '0 : winIdx + PTR_W'(1);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Write port, pointer and counter. The counter advances on the same edge
    // that loads the write, so wr_count already includes the write shown on
    // the port while RegWrite is high.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ptr           <= '0;
            WriteRegister <= '0;
            WriteData     <= '0;
            wrCount       <= '0;
        end else begin
            ptr <= ptrNext;
            if (commitValid) begin
                WriteRegister <= selAddr;
                WriteData     <= selData;
                if (wrCount != WR_COUNT_MAX) begin
                    wrCount <= wrCount + 16'd1;
                end
            end
        end
    end

    assign RegWrite = (state == ISSUE);
    assign wr_count = wrCount;
    assign fsmState = state;

`ifdef REGWB_BYPASS_EN
    // Forward the write currently on the port to a matching reader; the zero
    // register never forwards.
    always_comb begin
        fwd_hit1  = RegWrite && (WriteRegister == ReadRegister1) &&
                    (ReadRegister1 != ADDR_W'(ZERO_REG));
        fwd_hit2  = RegWrite && (WriteRegister == ReadRegister2) &&
                    (ReadRegister2 != ADDR_W'(ZERO_REG));
        fwd_data1 = fwd_hit1 ? WriteData : '0;
        fwd_data2 = fwd_hit2 ? WriteData : '0;
    end
`else
    assign fwd_hit1  = 1'b0;
    assign fwd_hit2  = 1'b0;
    assign fwd_data1 = '0;
    assign fwd_data2 = '0;

    logic unusedReadRegs;
    assign unusedReadRegs = ^{ReadRegister1, ReadRegister2};
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
// Directed self-checking bench for regfile_wb_arbiter (default parameters).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;
    import regwb_pkg::*;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;

`ifdef REGWB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    logic [N-1:0]    req;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    gnt;
    logic            RegWrite;
    logic [AW-1:0]   WriteRegister;
    logic [DW-1:0]   WriteData;
    logic [15:0]     wr_count;
    logic [AW-1:0]   ReadRegister1, ReadRegister2;
    logic            fwd_hit1, fwd_hit2;
    logic [DW-1:0]   fwd_data1, fwd_data2;
    regwb_state_e    fsmState;

    regfile_wb_arbiter #(
        .NUM_REQ (N),
        .ADDR_W  (AW),
        .DATA_W  (DW)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .req           (req),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .gnt           (gnt),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .wr_count      (wr_count),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .fwd_hit1      (fwd_hit1),
        .fwd_hit2      (fwd_hit2),
        .fwd_data1     (fwd_data1),
        .fwd_data2     (fwd_data2),
        .fsmState      (fsmState)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [N-1:0]  exp_q[$];   // expected grant vectors, in order
    logic [AW-1:0] wr_q[$];    // expected write addresses, one cycle behind

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    logic [N-1:0]  exp_g;
    logic [AW-1:0] exp_a;

    initial begin
        Reset         = 1'b1;
        req           = '0;
        req_addr      = '0;
        req_data      = '0;
        ReadRegister1 = '0;
        ReadRegister2 = '0;

        // ---- reset state, requests present during reset ----
        repeat (2) @(negedge Clk);
        set_req(0, 5'd3, 32'h11);
        set_req(1, 5'd4, 32'h22);
        set_req(2, 5'd5, 32'h33);
        req = 3'b111;
        #1;
        check("rst_gnt",      gnt, 0);
        check("rst_regwrite", RegWrite, 0);
        check("rst_wreg",     WriteRegister, 0);
        check("rst_wdata",    WriteData, 0);
        check("rst_wrcount",  wr_count, 0);
        check("rst_state",    fsmState, IDLE);
        @(negedge Clk);
        req   = '0;
        Reset = 1'b0;
        #1;
        check("idle_gnt", gnt, 0);

        // ---- single request ----
        @(negedge Clk);
        set_req(0, 5'd5, 32'h1234);
        req = 3'b001;
        #1;
        check("single_gnt", gnt, 3'b001);
        @(negedge Clk);
        req = '0;
        #1;
        check("single_regwrite", RegWrite, 1);
        check("single_wreg",     WriteRegister, 5);
        check("single_wdata",    WriteData, 32'h1234);
        check("single_wrcount",  wr_count, 1);
        check("single_state",    fsmState, ISSUE);
        check("single_gnt_drop", gnt, 0);
        @(negedge Clk);
        #1;
        check("nogrant_regwrite", RegWrite, 0);
        check("nogrant_wreg",     WriteRegister, 5);
        check("nogrant_wdata",    WriteData, 32'h1234);

        // ---- zero register (ptr is now 1) ----
        @(negedge Clk);
        set_req(1, 5'd0, 32'hFFFF_FFFF);
        req = 3'b010;
        #1;
        check("zero_gnt", gnt, 3'b010);
        @(negedge Clk);
        req = '0;
        #1;
        check("zero_regwrite", RegWrite, 0);
        check("zero_wrcount",  wr_count, 1);
        check("zero_wreg",     WriteRegister, 5);

        // ---- requester 2 alone (ptr 2 -> 0) ----
        @(negedge Clk);
        set_req(2, 5'd9, 32'h99);
        req = 3'b100;
        #1;
        check("r2_gnt", gnt, 3'b100);
        @(negedge Clk);
        req = '0;
        #1;
        check("r2_wreg",    WriteRegister, 9);
        check("r2_wrcount", wr_count, 2);

        // ---- fairness: req=111 for 6 cycles from ptr=0 ----
        set_req(0, 5'd1, 32'hA1);
        set_req(1, 5'd2, 32'hA2);
        set_req(2, 5'd3, 32'hA3);
        exp_q = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        for (int c = 0; c <= 6; c++) begin
            @(negedge Clk);
            req = (c < 6) ? 3'b111 : 3'b000;
            #1;
            if (c >= 1) begin
                exp_a = wr_q.pop_front();
                check("fair_regwrite", RegWrite, 1);
                check("fair_wreg",     WriteRegister, exp_a);
            end
            if (c < 6) begin
                exp_g = exp_q.pop_front();
                check("fair_gnt", gnt, exp_g);
                // requester i writes address i+1
                wr_q.push_back((exp_g == 3'b001) ? 5'd1 : (exp_g == 3'b010) ? 5'd2 : 5'd3);
            end
        end
        @(negedge Clk);
        #1;
        check("fair_end_regwrite", RegWrite, 0);
        check("fair_end_wrcount",  wr_count, 8);

        // ---- bypass ----
        @(negedge Clk);
        set_req(0, 5'd7, 32'hCAFE);
        req           = 3'b001;
        ReadRegister1 = 5'd7;
        ReadRegister2 = 5'd0;
        #1;
        check("byp_gnt",      gnt, 3'b001);
        check("byp_idle_hit", fwd_hit1, 0);
        @(negedge Clk);
        req = '0;
        #1;
        check("byp_regwrite", RegWrite, 1);
        check("byp_hit1",     fwd_hit1, BYP);
        check("byp_data1",    fwd_data1, BYP ? 32'hCAFE : 32'h0);
        check("byp_hit2_r0",  fwd_hit2, 0);
        check("byp_data2_r0", fwd_data2, 0);
        check("byp_wrcount",  wr_count, 9);
        ReadRegister2 = 5'd7;
        #1;
        check("byp_hit2",  fwd_hit2, BYP);
        check("byp_data2", fwd_data2, BYP ? 32'hCAFE : 32'h0);

        // ---- reset between grant and commit edge (ptr is now 1) ----
        @(negedge Clk);
        ReadRegister1 = '0;
        ReadRegister2 = '0;
        set_req(1, 5'd6, 32'hBEEF);
        req = 3'b010;
        #1;
        check("mid_gnt", gnt, 3'b010);
        #1;
        Reset = 1'b1;
        #1;
        check("mid_gnt_in_reset", gnt, 0);
        @(negedge Clk);
        #1;
        check("mid_regwrite", RegWrite, 0);
        check("mid_wrcount",  wr_count, 0);
        check("mid_wreg",     WriteRegister, 0);
        check("mid_wdata",    WriteData, 0);
        @(negedge Clk);
        Reset = 1'b0;
        set_req(2, 5'd4, 32'h44);
        req = 3'b100;
        #1;
        check("post_rst_gnt", gnt, 3'b100);
        @(negedge Clk);
        req = '0;
        #1;
        check("post_rst_regwrite", RegWrite, 1);
        check("post_rst_wreg",     WriteRegister, 4);
        check("post_rst_wrcount",  wr_count, 1);

        // ---- saturation under continuous requests ----
        @(negedge Clk);
        set_req(0, 5'd1, 32'h1);
        set_req(1, 5'd2, 32'h2);
        set_req(2, 5'd3, 32'h3);
        req = 3'b111;
        repeat (16'hFFFB) @(negedge Clk);
        #1;
        check("sat_near",     wr_count, 16'hFFFC);
        check("sat_regwrite", RegWrite, 1);
        repeat (3) @(negedge Clk);
        #1;
        check("sat_reach", wr_count, 16'hFFFF);
        repeat (2) @(negedge Clk);
        #1;
        check("sat_hold",          wr_count, 16'hFFFF);
        check("sat_hold_regwrite", RegWrite, 1);
        @(negedge Clk);
        req = '0;
        #1;
        check("sat_last", wr_count, 16'hFFFF);
        @(negedge Clk);
        #1;
        check("sat_end_regwrite", RegWrite, 0);
        check("sat_end_wrcount",  wr_count, 16'hFFFF);

        // ---- report ----
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
